// File: rtl/instruction_sequencer_pkg.sv
// Shared sequencer definitions: FSM states, one-hot step codes, PC increment
// and the opcode constants the control units decode against.
package sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    FAULT   = 2'd2
  } seq_state_e;

  localparam logic [4:0] STEP_NONE = 5'b00000;
  localparam logic [4:0] STEP1     = 5'b00001;
  localparam logic [4:0] STEP2     = 5'b00010;
  localparam logic [4:0] STEP3     = 5'b00100;
  localparam logic [4:0] STEP4     = 5'b01000;
  localparam logic [4:0] STEP5     = 5'b10000;

  localparam logic [31:0] PC_INCR = 32'd4;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/instruction_sequencer_if.sv
// Fetch bus plus the step/field/done link between the sequencer (master)
// and the memory and control units (slave).
interface instruction_sequencer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic        pc_load;
  logic [31:0] pc_target;
  logic [4:0]  instruction_counter;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic        fault;

  modport master (
    output mem_req, mem_addr, instruction_counter,
    output opcode, funct7, rd, rs1, rs2, funct3, pc, fault,
    input  mem_ack, mem_rdata, done, pc_load, pc_target
  );

  modport slave (
    input  mem_req, mem_addr, instruction_counter,
    input  opcode, funct7, rd, rs1, rs2, funct3, pc, fault,
    output mem_ack, mem_rdata, done, pc_load, pc_target
  );
endinterface

// File: rtl/instruction_sequencer_field_split.sv
// Purely combinational RV32 field slicing of an instruction word.
module instruction_field_split (
  input  logic [31:0] i_ir,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_rd,
  output logic [2:0]  o_funct3,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [6:0]  o_funct7
);
  assign o_opcode = i_ir[6:0];
  assign o_rd     = i_ir[11:7];
  assign o_funct3 = i_ir[14:12];
  assign o_rs1    = i_ir[19:15];
  assign o_rs2    = i_ir[24:20];
  assign o_funct7 = i_ir[31:25];
endmodule

// File: rtl/instruction_sequencer.sv
// Fetch-and-step sequencer: fetches an instruction, then walks a one-hot step
// vector until done. Optional fetch-ack timeout under `SEQ_FETCH_TIMEOUT_EN.
module instruction_sequencer
  import sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input logic                     clk,
  input logic                     resetn,
  instruction_sequencer_if.master bus
);

  seq_state_e  r_state;
  seq_state_e  w_state_nxt;
  logic        r_started;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [4:0]  r_counter;
  logic        w_mem_req;
  logic        w_fault;
  logic        w_ack;
  logic        w_last_step;
  logic [6:0]  w_opcode;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;

  assign w_ack       = w_mem_req & bus.mem_ack;
  assign w_last_step = (r_counter == STEP5);

`ifdef SEQ_FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            w_timeout;

  // Counts consecutive unanswered request cycles; the last one trips the fault.
  assign w_timeout = w_mem_req & ~bus.mem_ack &
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_to_cnt <= '0;
    end else if (!w_mem_req || bus.mem_ack) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH: begin
        if (w_ack) begin
          w_state_nxt = EXECUTE;
        end
`ifdef SEQ_FETCH_TIMEOUT_EN
        else if (w_timeout) begin
          w_state_nxt = FAULT;
        end
`endif
      end
      EXECUTE: begin
        // done on the final step still completes the instruction normally
        if (bus.done) begin
          w_state_nxt = FETCH;
        end else if (w_last_step) begin
          w_state_nxt = FAULT;
        end
      end
      FAULT:   w_state_nxt = FAULT;
      default: w_state_nxt = FAULT;
    endcase
  end

  // The request is held off for the first cycle out of reset.
  always_comb begin
    w_mem_req = 1'b0;
    w_fault   = 1'b0;
    case (r_state)
      FETCH:   w_mem_req = r_started;
      FAULT:   w_fault   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_counter <= STEP_NONE;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_ack) begin
            r_ir      <= bus.mem_rdata;
            r_counter <= STEP1;
          end
        end
        EXECUTE: begin
          if (bus.done) begin
            r_counter <= STEP_NONE;
            r_pc      <= bus.pc_load ? bus.pc_target : (r_pc + PC_INCR);
          end else if (w_last_step) begin
            r_counter <= STEP_NONE;
          end else begin
            r_counter <= {r_counter[3:0], 1'b0};
          end
        end
        default: r_counter <= STEP_NONE;
      endcase
    end
  end

  instruction_field_split u_field_split (
    .i_ir     (r_ir),
    .o_opcode (w_opcode),
    .o_rd     (w_rd),
    .o_funct3 (w_funct3),
    .o_rs1    (w_rs1),
    .o_rs2    (w_rs2),
    .o_funct7 (w_funct7)
  );

  assign bus.mem_req             = w_mem_req;
  assign bus.mem_addr            = r_pc;
  assign bus.pc                  = r_pc;
  assign bus.instruction_counter = r_counter;
  assign bus.fault               = w_fault;
  assign bus.opcode              = w_opcode;
  assign bus.funct7              = w_funct7;
  assign bus.rd                  = w_rd;
  assign bus.rs1                 = w_rs1;
  assign bus.rs2                 = w_rs2;
  assign bus.funct3              = w_funct3;

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Fetch-and-step sequencer that drives the per-instruction control units. It fetches a 32-bit instruction word over a request/acknowledge memory handshake and splits it into RV32 fields. It then issues the one-hot `instruction_counter` step vector, advancing one step per cycle until a control unit raises `done`. It owns the program counter and is the upstream end of the `instruction_counter` / field / `done` interface.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `TIMEOUT_CYCLES`, 16: fetch-ack timeout; used only with `SEQ_FETCH_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  fetch request.
- `mem_addr`  out  32  fetch address; equals `pc`.
- `mem_ack`  in  1  fetch acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  instruction word.
- `done`  in  1  instruction complete, from the control units.
- `pc_load`  in  1  redirect request; sampled only together with `done`.
- `pc_target`  in  32  redirect target.
- `instruction_counter`  out  5  one-hot step vector; 0 when not executing.
- `opcode`, `funct7`  out  7  from IR[6:0] and IR[31:25].
- `rd`, `rs1`, `rs2`  out  5  from IR[11:7], IR[19:15] and IR[24:20].
- `funct3`  out  3  from IR[14:12].
- `pc`  out  32  address of the current instruction.
- `fault`  out  1  sticky error flag.

## Operation
States:
- FETCH
  - `mem_req`=1 and `mem_addr`=`pc`, both held stable until `mem_ack` is sampled high.
  - On ack: IR <= `mem_rdata`, `instruction_counter` <= 5'b00001, go to EXECUTE.
- EXECUTE
  - `mem_req`=0.
  - `done` high: counter <= 0 and go to FETCH. `pc` <= `pc_target` if `pc_load` is high, else `pc`+4.
  - `done` low with counter < 5'b10000: counter shifts left one position.
  - `done` low with counter = 5'b10000: go to FAULT.
- FAULT
  - `fault`=1, `mem_req`=0, counter=0.
  - Held until reset.

Rules:
- `mem_ack` is ignored while `mem_req`=0.
- The field outputs are combinational slices of IR. IR changes only on an accepted fetch.
- PC arithmetic is 32-bit unsigned and wraps: 32'hFFFF_FFFC+4 = 0.
- `pc_load` and `pc_target` are ignored when `done` is low.
- `done` sampled in the same cycle as the step-5 check wins: it completes the instruction normally, with no fault.

## Timing
- Reset values, applied asynchronously:
  - state FETCH; `mem_req`=0.
  - `pc` = `mem_addr` = `RESET_PC`.
  - IR, all field outputs and `instruction_counter` = 0.
  - `fault`=0.
- `mem_req` rises in the first cycle after `resetn` deasserts.
- Fetch latency: `mem_req` high in cycle N with `mem_ack` in cycle N+k; `instruction_counter`=00001 in cycle N+k+1.
- Step k of the instruction is visible in cycle N+k+k'.
- `done` sampled in step s: the next fetch request starts in the following cycle. Per-instruction cost is (fetch cycles + s).
- Back-to-back: the minimum cycle count is 2 per instruction (ack in the same cycle as req, `done` at step 1).
- Reset mid-operation (fetch or execute) clears everything immediately. No partial PC update survives.

## Configuration
- `SEQ_FETCH_TIMEOUT_EN` defined:
  - A counter runs while FETCH waits for ack.
  - If `TIMEOUT_CYCLES` consecutive request cycles pass without ack, go to FAULT.
  - The counter clears on ack.
- Not defined: FETCH waits indefinitely. The timeout counter and its logic are absent.

## Structure
- Shared package `sequencer_pkg`:
  - state enum {FETCH, EXECUTE, FAULT}.
  - one-hot step constants `STEP1`..`STEP5`.
  - `PC_INCR` = 4.
  - opcode constants shared with the control units (e.g. `OP_LUI` = 7'b0110111, `OP_IMM` = 7'b0010011, `OP_REG` = 7'b0110011).
- Sub-module `instruction_field_split`: purely combinational slicing of IR into the field outputs. Reused by the verification models.

## Test plan
- Reset: hold `resetn`=0 → all outputs at reset values, `mem_req`=0. Release → `mem_req`=1 with `mem_addr`=0 on the next cycle.
- Delayed fetch: ack after 3 wait cycles with `mem_rdata`=32'h0050_0093.
  - During the wait, `mem_addr` stays stable.
  - After ack: `opcode`=7'h13, `rd`=1, `rs1`=0, `rs2`=5, `funct7`=0, `funct3`=0.
  - Counter steps 00001, 00010, 00100; `done` at 00100 → next `mem_addr`=4.
- Redirect: `done` with `pc_load`=1 and `pc_target`=32'h100 at step 2 → next fetch at 32'h100. Same case with `pc_load`=0 → 32'h104.
- Runaway: `done` never asserted → counter reaches 10000, then `fault`=1, `mem_req`=0 and counter=0, held until reset.
- Wrap and mid-op reset:
  - `pc`=32'hFFFF_FFFC completes → next fetch at 0.
  - Assert `resetn` low during step 3 → counter=0 immediately; after release, fetch at `RESET_PC`.
- `SEQ_FETCH_TIMEOUT_EN` with `TIMEOUT_CYCLES`=16:
  - No ack for 16 request cycles → `fault`=1.
  - Ack on the 15th cycle → normal execution, no fault.
